// File: rtl/sn_spike_recorder.sv
// Spike event recorder: timestamps evaluation periods that carry output spikes
// into a small FIFO drained by the host through the protocol register window.
module sn_spike_recorder #(
  parameter int         P_NUM_OUTPUTS = 1,
  parameter int         P_FIFO_DEPTH  = 16,
  parameter logic [6:0] P_BASE_ADDR   = 7'h60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nc_evaluate,
  input  logic [P_NUM_OUTPUTS-1:0] spike_in,
  input  logic                     prot_enable,
  input  logic                     prot_r0w1,
  input  logic [6:0]               prot_addr,
  input  logic [7:0]               prot_wdata,
  output logic [7:0]               prot_rdata,
  output logic                     addr_hit,
  output logic                     fifo_nonempty
);

  localparam int PW = $clog2(P_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_STATUS = 3'd1,
    OFF_TS_LO  = 3'd2,
    OFF_TS_HI  = 3'd3,
    OFF_MASK   = 3'd4,
    OFF_POP    = 3'd5
  } reg_off_e;

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    ts_q, ts_d;
  logic           record_en_q, record_en_d;
  logic           overflow_q, overflow_d;
  logic           fifo_nonempty_q, fifo_nonempty_d;

  logic [15:0]              ts_mem   [P_FIFO_DEPTH];
  logic [P_NUM_OUTPUTS-1:0] mask_mem [P_FIFO_DEPTH];

  logic [6:0] offset;
  reg_off_e   reg_off;
  logic       in_range, wr_ctrl, clear, pop_req, pop_do, evt, push_req, push_do, empty;

  // Decode: the subtraction wraps below the base, so the >= guard is required.
  always_comb begin
    offset   = prot_addr - P_BASE_ADDR;
    in_range = (prot_addr >= P_BASE_ADDR) && (offset <= 7'd5);
    addr_hit = prot_enable && in_range;
    reg_off  = reg_off_e'(offset[2:0]);
    wr_ctrl  = addr_hit && prot_r0w1 && (reg_off == OFF_CTRL);
    clear    = wr_ctrl && prot_wdata[1];
    pop_req  = addr_hit && prot_r0w1 && (reg_off == OFF_POP);
    empty    = (count_q == '0);
    pop_do   = pop_req && !empty && !clear;
    evt      = nc_evaluate && record_en_q;
    push_req = evt && (|spike_in);
    // A pop in the same cycle frees the slot before the push lands.
    push_do  = push_req && ((count_q != FULL_COUNT) || pop_do) && !clear;
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ts_d        = ts_q;
    record_en_d = record_en_q;
    overflow_d  = overflow_q;

    if (evt) ts_d = ts_q + 16'd1;
    if (push_req && !push_do) overflow_d = 1'b1;
    if (push_do) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_do)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_do, pop_do})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_ctrl) record_en_d = prot_wdata[0];
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ts_d       = '0;
      overflow_d = 1'b0;
    end
    fifo_nonempty_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      ts_q            <= '0;
      record_en_q     <= 1'b0;
      overflow_q      <= 1'b0;
      fifo_nonempty_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      ts_q            <= ts_d;
      record_en_q     <= record_en_d;
      overflow_q      <= overflow_d;
      fifo_nonempty_q <= fifo_nonempty_d;
    end
  end

  // NOTE: the entry storage has no reset so it maps onto plain RAM; reads of
  // stale slots are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push_do) begin
      ts_mem[wr_ptr_q]   <= ts_q;
      mask_mem[wr_ptr_q] <= spike_in;
    end
  end

  always_comb begin
    prot_rdata = '0;
    if (addr_hit) begin
      case (reg_off)
        OFF_CTRL:   prot_rdata = {7'd0, record_en_q};
        OFF_STATUS: prot_rdata = {overflow_q, 7'(count_q)};
        OFF_TS_LO:  prot_rdata = empty ? 8'd0 : ts_mem[rd_ptr_q][7:0];
        OFF_TS_HI:  prot_rdata = empty ? 8'd0 : ts_mem[rd_ptr_q][15:8];
        OFF_MASK:   prot_rdata = empty ? 8'd0 : 8'(mask_mem[rd_ptr_q]);
        default:    prot_rdata = '0;
      endcase
    end
  end

  assign fifo_nonempty = fifo_nonempty_q;

endmodule

// File: tb/tb_sn_spike_recorder.sv
// Scoreboard bench for sn_spike_recorder: a behavioural FIFO model queues the
// expected entries as spikes are driven; register reads compare the head.
module tb_sn_spike_recorder;

  localparam int         N     = 3;
  localparam int         DEPTH = 16;
  localparam logic [6:0] BASE  = 7'h60;
  localparam logic [2:0] O_CTRL = 3'd0, O_STATUS = 3'd1, O_TS_LO = 3'd2,
                         O_TS_HI = 3'd3, O_MASK = 3'd4, O_POP = 3'd5;

  typedef struct packed {
    logic [15:0]  ts;
    logic [N-1:0] mask;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         nc_evaluate = 1'b0;
  logic [N-1:0] spike_in = '0;
  logic         prot_enable = 1'b0;
  logic         prot_r0w1 = 1'b0;
  logic [6:0]   prot_addr = '0;
  logic [7:0]   prot_wdata = '0;
  logic [7:0]   prot_rdata;
  logic         addr_hit;
  logic         fifo_nonempty;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  entry_t      exp_q[$];
  logic [15:0] m_ts  = '0;
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  logic        m_en  = 1'b0;

  sn_spike_recorder #(
    .P_NUM_OUTPUTS(N),
    .P_FIFO_DEPTH (DEPTH),
    .P_BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .nc_evaluate  (nc_evaluate),
    .spike_in     (spike_in),
    .prot_enable  (prot_enable),
    .prot_r0w1    (prot_r0w1),
    .prot_addr    (prot_addr),
    .prot_wdata   (prot_wdata),
    .prot_rdata   (prot_rdata),
    .addr_hit     (addr_hit),
    .fifo_nonempty(fifo_nonempty)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_ts = '0; m_count = 0; m_ovf = 1'b0; m_en = 1'b0;
  endfunction

  function automatic void model_eval(input logic [N-1:0] spk);
    if (m_en) begin
      if (spk != '0) begin
        if (m_count < DEPTH) begin
          exp_q.push_back('{ts: m_ts, mask: spk});
          m_count++;
        end else m_ovf = 1'b1;
      end
      m_ts = m_ts + 16'd1;
    end
  endfunction

  function automatic void model_pop();
    if (m_count > 0) begin
      m_count--;
      void'(exp_q.pop_front());
    end
  endfunction

  function automatic void model_ctrl(input logic [7:0] d);
    m_en = d[0];
    if (d[1]) begin
      exp_q.delete();
      m_ts = '0; m_count = 0; m_ovf = 1'b0;
    end
  endfunction

  task automatic drive_idle();
    prot_enable = 1'b0; prot_r0w1 = 1'b0; nc_evaluate = 1'b0; spike_in = '0;
  endtask

  // One raw bus cycle, optionally combined with an evaluation pulse.
  task automatic raw_cycle(input logic en, input logic wr, input logic [6:0] addr,
                           input logic [7:0] wd, input logic ev, input logic [N-1:0] spk);
    @(negedge clk);
    prot_enable = en; prot_r0w1 = wr; prot_addr = addr; prot_wdata = wd;
    nc_evaluate = ev; spike_in = spk;
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [7:0] d);
    raw_cycle(1'b1, 1'b1, BASE + 7'(off), d, 1'b0, '0);
    if (off == O_CTRL) model_ctrl(d);
    if (off == O_POP) model_pop();
  endtask

  task automatic reg_read(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    prot_enable = 1'b1; prot_r0w1 = 1'b0; prot_addr = BASE + 7'(off);
    #1 d = prot_rdata;
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic evaluate(input logic [N-1:0] spk);
    raw_cycle(1'b0, 1'b0, '0, '0, 1'b1, spk);
    model_eval(spk);
  endtask

  task automatic check_status(input string tag);
    logic [7:0] d;
    reg_read(O_STATUS, d);
    check({tag, "_status"}, d, {m_ovf, 7'(m_count)});
    check({tag, "_nonempty"}, fifo_nonempty, (m_count != 0));
  endtask

  // Compare the head against the scoreboard, then pop it.
  task automatic check_head(input string tag);
    logic [7:0] lo, hi, mk;
    entry_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underrun"}, 0, 1);
    end else begin
      e = exp_q[0];
      reg_read(O_TS_LO, lo);
      reg_read(O_TS_HI, hi);
      reg_read(O_MASK, mk);
      check({tag, "_ts"}, {hi, lo}, e.ts);
      check({tag, "_mask"}, mk, 8'(e.mask));
    end
    reg_write(O_POP, 8'h00);
  endtask

  initial begin
    logic [7:0] d;

    // Reset state
    #3;
    check("rst_nonempty", fifo_nonempty, 0);
    check("rst_addr_hit", addr_hit, 0);
    check("rst_rdata", prot_rdata, 0);
    #20 rst = 1'b1;
    model_reset();
    check_status("rst");
    reg_read(O_CTRL, d);
    check("rst_ctrl", d, 8'h00);

    // Out-of-range address: no hit, no data
    @(negedge clk);
    prot_enable = 1'b1; prot_r0w1 = 1'b0; prot_addr = 7'h66;
    #1 check("oor_hit", addr_hit, 0);
    check("oor_rdata", prot_rdata, 0);
    prot_addr = BASE + 7'd1;
    #1 check("inr_hit", addr_hit, 1);
    @(posedge clk);
    #1 drive_idle();

    // Basic recording: spike only in the second period
    reg_write(O_CTRL, 8'h01);
    evaluate(3'b000);
    evaluate(3'b001);
    evaluate(3'b000);
    check_status("basic");
    check_head("basic");
    // Second pop on empty must not underflow
    reg_write(O_POP, 8'h00);
    check_status("pop_empty");
    reg_read(O_TS_LO, d);
    check("empty_ts_lo", d, 0);
    reg_read(O_MASK, d);
    check("empty_mask", d, 0);

    // Overflow: 20 spiking periods into 16 entries
    reg_write(O_CTRL, 8'h03);
    for (int i = 0; i < 20; i++) evaluate(3'b101);
    check_status("ovf");
    for (int i = 0; i < DEPTH; i++) check_head($sformatf("ovf_e%0d", i));
    check_status("ovf_drained");

    // Full FIFO with same-cycle pop and push
    reg_write(O_CTRL, 8'h03);
    for (int i = 0; i < DEPTH; i++) evaluate(3'(i % 7 + 1));
    check_status("full");
    raw_cycle(1'b1, 1'b1, BASE + 7'(O_POP), 8'h00, 1'b1, 3'b110);
    model_pop();
    model_eval(3'b110);
    check_status("full_pp");
    // Writes to read-only offsets and out-of-range addresses are ignored
    reg_write(O_STATUS, 8'hFF);
    raw_cycle(1'b1, 1'b1, 7'h10, 8'h03, 1'b0, '0);
    check_status("ro_write");
    for (int i = 0; i < DEPTH; i++) check_head($sformatf("full_e%0d", i));

    // Timestamp wrap
    reg_write(O_CTRL, 8'h03);
    @(negedge clk);
    nc_evaluate = 1'b1; spike_in = '0;
    repeat (65535) @(posedge clk);
    #1 drive_idle();
    m_ts = m_ts + 16'd65535;
    evaluate(3'b001);
    evaluate(3'b010);
    check_status("wrap");
    check_head("wrap_ffff");
    check_head("wrap_0000");

    // Clear coinciding with a spike: spike discarded, ts restarts at 0
    evaluate(3'b011);
    evaluate(3'b100);
    raw_cycle(1'b1, 1'b1, BASE + 7'(O_CTRL), 8'h03, 1'b1, 3'b111);
    model_ctrl(8'h03);
    check_status("clr");
    reg_read(O_CTRL, d);
    check("clr_ctrl", d, 8'h01);
    evaluate(3'b100);
    check_head("clr_first");

    // Disable holds ts; re-enable continues from the held value
    reg_write(O_CTRL, 8'h00);
    evaluate(3'b111);
    evaluate(3'b111);
    check_status("disabled");
    reg_write(O_CTRL, 8'h01);
    evaluate(3'b010);
    check_head("reenable");

    // Asynchronous reset in the middle of a read
    evaluate(3'b001);
    evaluate(3'b001);
    @(negedge clk);
    prot_enable = 1'b1; prot_r0w1 = 1'b0; prot_addr = BASE + 7'(O_STATUS);
    #1 check("pre_arst_status", prot_rdata, {m_ovf, 7'(m_count)});
    #1 rst = 1'b0;
    #1 check("arst_status", prot_rdata, 0);
    check("arst_nonempty", fifo_nonempty, 0);
    drive_idle();
    model_reset();
    #10 rst = 1'b1;
    check_status("post_arst");
    reg_read(O_CTRL, d);
    check("post_arst_ctrl", d, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sn_spike_recorder.md
Name: sn_spike_recorder

Overview:
- Sits directly downstream of the spiking network.
- Samples the output-neuron spike vector on every evaluation pulse (nc_evaluate).
- Timestamps periods with spikes and pushes them into a small FIFO.
- Exposes the FIFO through the 7-bit-address / 8-bit-data protocol register interface, so the host drains spike events over UART instead of polling membrane state.

Parameters:
P_NUM_OUTPUTS, 1, number of output neurons recorded; legal range 1..8.
P_FIFO_DEPTH, 16, event FIFO entries; power of 2, 2..64.
P_BASE_ADDR, 7'h60, protocol address of register offset 0; offsets 0..5 are decoded.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
nc_evaluate  input  1  one-cycle pulse per network evaluation period.
spike_in  input  P_NUM_OUTPUTS  output-neuron spike flags; valid in the cycle nc_evaluate=1.
prot_enable  input  1  protocol transaction strobe, one cycle.
prot_r0w1  input  1  0=read, 1=write.
prot_addr  input  7  register address.
prot_wdata  input  8  write data.
prot_rdata  output  8  read data; combinational, valid while prot_enable=1 and addr_hit=1, else 0.
addr_hit  output  1  combinational; 1 when prot_addr is in P_BASE_ADDR..P_BASE_ADDR+5.
fifo_nonempty  output  1  registered; 1 when count>0.

Behaviour:
- Reset (rst=0, async): FIFO empty; rd_ptr=wr_ptr=count=0; ts=0; record_en=0; overflow=0; fifo_nonempty=0. prot_rdata and addr_hit are combinational and resolve to 0 while prot_enable=0.
- Registers, by offset:
  - 0 CTRL (R/W): bit0 record_en. bit1 clear is write-1 and self-clearing; it reads 0.
  - 1 STATUS (RO): [6:0] count, [7] overflow (sticky).
  - 2 TS_LO (RO): head entry timestamp [7:0].
  - 3 TS_HI (RO): head entry timestamp [15:8].
  - 4 MASK (RO): head spike mask, zero-extended to 8 bits.
  - 5 POP (WO): any write pops the head entry; reads return 0.
  - Writes to RO offsets are ignored. Reads of offsets 2-4 while empty return 0.
- Timestamp counter ts (16-bit):
  - Increments by 1 on each nc_evaluate while record_en=1.
  - Wraps 0xFFFF->0x0000.
  - Holds when record_en=0.
- Push:
  - Occurs in the cycle nc_evaluate=1, record_en=1 and |spike_in=1.
  - Entry = {ts (pre-increment value), spike_in}.
  - Periods with no spikes push nothing but still advance ts.
  - The entry is visible to reads from the next cycle (1-cycle write latency).
- Full: a push with count==P_FIFO_DEPTH is dropped, overflow is set to 1, and ts still advances.
- Pop: a POP write with count>0 advances rd_ptr and decrements count next cycle. A POP write while empty is ignored and does not underflow.
- Simultaneous push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, the pop frees the slot first, so the push is accepted and overflow is not set.
  - When empty, the pop is ignored and the push proceeds.
- Clear (CTRL write with bit1=1):
  - Next cycle: pointers, count, ts and overflow go to 0.
  - A push or pop in the same cycle is discarded.
  - record_en takes the bit0 value of the same write.
- Enable-only write (bit1=0): updates record_en. A 0->1 transition does not reset ts.
- Pointers: log2(P_FIFO_DEPTH) bits, wrapping naturally. count is log2(P_FIFO_DEPTH)+1 bits and saturates at P_FIFO_DEPTH.
- Out-of-range address: addr_hit=0, prot_rdata=0, no state change.
- Asserting rst mid-transaction: all state returns to reset values immediately.

Test Plan:
- Reset, write CTRL=0x01, 3 nc_evaluate pulses with spike_in=1 on the 2nd only -> STATUS=0x01, TS_LO=0x01, TS_HI=0x00, MASK=0x01.
- P_NUM_OUTPUTS=3, 20 consecutive spiking periods with spike_in=3'b101, no pops, depth 16 -> STATUS=0x90; first pop gives TS=0, MASK=0x05; the 16th entry has TS=15.
- FIFO full, POP write and spiking nc_evaluate in the same cycle -> STATUS=0x10, overflow stays 0, and the newest entry is retained at the tail.
- POP written twice with one entry stored -> count 0, fifo_nonempty=0, TS_LO/MASK read 0, no underflow.
- ts preloaded via 65535 non-spiking enabled periods, then a spiking period -> entry TS=0xFFFF, and the next spiking entry has TS=0x0000.
- Clear with CTRL=0x03 written while an nc_evaluate spike arrives the same cycle -> STATUS=0x00, ts=0, record_en=1; a subsequent spike records TS=0.
